// File: rtl/fetch_pkg_da.sv
// Shared types and constants for the instruction-fetch queue.
// Entry layout is {pc, instr}, pc in the upper half.
package fetch_pkg_da;

  localparam int XLEN_DEF    = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN_DEF-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_da.sv
// Synchronous FIFO with sync clear; clear beats push/pop.
// Head data is read straight from the storage registers.
module sync_fifo_da
  import fetch_pkg_da::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !i_clr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/inst_fetch_queue_da.sv
// PC owner and in-order fetch with credit-limited requests.
// Stale responses after a redirect are counted out via r_discard.
module inst_fetch_queue_da
  import fetch_pkg_da::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            flush_o
);

  localparam int CW = cnt_width(QDEPTH);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic            r_flush;

  logic [XLEN-1:0]   w_pc_nxt;
  logic [CW-1:0]     w_out_nxt;
  logic [CW-1:0]     w_disc_nxt;
  logic [CW:0]       w_inuse;
  logic              w_credit;
  logic              w_accept;
  logic              w_drop;
  logic              w_keep;
  logic              w_deq;
  logic [XLEN-1:0]   w_rsp_pc;
  logic [2*XLEN-1:0] w_head;
  logic [CW-1:0]     w_q_count;
  logic              w_q_empty;
  logic              w_q_full;
  logic [CW-1:0]     w_f_count;
  logic              w_f_empty;
  logic              w_f_full;
  logic              w_unused;

  // Queue slots are reserved at request time, so the queue cannot overflow.
  assign w_inuse  = {1'b0, w_q_count} + {1'b0, r_outstanding};
  assign w_credit = (w_inuse < (CW+1)'(QDEPTH));

  assign imem_req_valid = ~reset & ~redirect_valid & w_credit;
  assign imem_req_addr  = r_pc;

  assign w_accept = imem_req_valid & imem_req_ready;
  assign w_drop   = imem_rsp_valid & (r_discard != '0);
  assign w_keep   = imem_rsp_valid & ~w_drop & ~redirect_valid;
  assign w_deq    = id_valid & id_ready;

  assign id_valid = ~w_q_empty;
  assign id_pc    = id_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign id_instr = id_valid ? w_head[XLEN-1:0] : XLEN'(NOP_INSTR);
  assign flush_o  = r_flush;

  assign w_unused = &{1'b0, w_q_full, w_f_full, w_f_empty, w_f_count};

  sync_fifo_da #(
    .WIDTH (XLEN),
    .DEPTH (QDEPTH)
  ) u_inflight (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (1'b0),
    .i_push  (w_accept),
    .i_pop   (imem_rsp_valid),
    .i_wdata (r_pc),
    .o_rdata (w_rsp_pc),
    .o_full  (w_f_full),
    .o_empty (w_f_empty),
    .o_count (w_f_count)
  );

  sync_fifo_da #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (redirect_valid),
    .i_push  (w_keep),
    .i_pop   (w_deq),
    .i_wdata ({w_rsp_pc, imem_rsp_data}),
    .o_rdata (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_comb begin
    w_pc_nxt   = r_pc;
    w_out_nxt  = r_outstanding;
    w_disc_nxt = r_discard;
    unique case ({w_accept, imem_rsp_valid})
      2'b10:   w_out_nxt = r_outstanding + 1'b1;
      2'b01:   w_out_nxt = r_outstanding - 1'b1;
      default: w_out_nxt = r_outstanding;
    endcase
    unique case (1'b1)
      redirect_valid: begin
        w_pc_nxt   = {redirect_pc[XLEN-1:2], 2'b00};
        // Everything still in flight after this cycle is stale.
        w_disc_nxt = r_outstanding - CW'(imem_rsp_valid);
      end
      w_accept: begin
        w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
        if (w_drop) w_disc_nxt = r_discard - 1'b1;
      end
      default: begin
        if (w_drop) w_disc_nxt = r_discard - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_flush       <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_disc_nxt;
      r_flush       <= redirect_valid;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue_da.sv
// Bench for inst_fetch_queue_da: in-order memory model plus
// a scoreboard of accepted fetches checked at every dequeue.
module tb_inst_fetch_queue_da;
  import fetch_pkg_da::*;

  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        flush_o;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  deq_log[$];
  fetch_entry_t obs_e;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int cyc   = 0;
  int lat   = 1;
  bit rnd_ready = 0;

  inst_fetch_queue_da #(
    .XLEN     (XLEN),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .flush_o        (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: drives responses in order, lat cycles after acceptance.
  always @(posedge clk) begin
    #2;
    cyc++;
    imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mk_instr(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Observer: record accepts, compare every dequeue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend.delete();
    end else begin
      if (id_valid && id_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL deq_unexpected: got pc=%h, required no entry", id_pc);
        end else begin
          obs_e = exp_q.pop_front();
          deq_log.push_back(id_pc);
          if (id_pc !== obs_e.pc || id_instr !== obs_e.instr) begin
            n_err++;
            $display("FAIL deq_order: got pc=%h instr=%h, required pc=%h instr=%h",
                     id_pc, id_instr, obs_e.pc, obs_e.instr);
          end
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL redirect_req: got req_valid=%b, required 0", imem_req_valid);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back('{pc: imem_req_addr, instr: mk_instr(imem_req_addr)});
        n_acc++;
      end
      n_vec++;
      if (exp_q.size() > QDEPTH) begin
        n_err++;
        $display("FAIL credit: got %0d live fetches, required <= %0d",
                 exp_q.size(), QDEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    redirect_valid = 1'b0;
    n_acc = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_id(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      smp();
      if (id_valid) begin
        ok = 1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: got no id_valid, required one within 30 cycles", nm);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    smp();
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid);
    end
    n_vec++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_id_valid: got %b, required 0", id_valid);
    end
    n_vec++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_id_data: got pc=%h instr=%h, required 0/0", id_pc, id_instr);
    end
    n_vec++;
    if (flush_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flush: got %b, required 0", flush_o);
    end
    n_vec++;
    if (imem_req_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL rst_pc: got %h, required %h", imem_req_addr, RESET_PC);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    bit gap;
    smp();
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL stream_first_req: got v=%b a=%h, required v=1 a=0",
               imem_req_valid, imem_req_addr);
    end
    step();
    smp();
    n_vec++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_early: got id_valid=%b, required 0", id_valid);
    end
    step();
    smp();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL stream_latency: got v=%b pc=%h, required v=1 pc=0", id_valid, id_pc);
    end
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      smp();
      if (id_valid !== 1'b1) gap = 1;
    end
    n_vec++;
    if (gap !== 1'b0) begin
      n_err++;
      $display("FAIL stream_rate: got bubble, required 1 instr/cycle");
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    lat = 1;
    apply_reset();
    for (int i = 0; i < 10; i++) step();
    n_vec++;
    if (n_acc !== 4) begin
      n_err++;
      $display("FAIL bp_requests: got %0d, required 4", n_acc);
    end
    n_vec++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL bp_full: got req=%b idv=%b pc=%h, required 0/1/0",
               imem_req_valid, id_valid, id_pc);
    end
    deq_log.delete();
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (deq_log.size() <= k) begin
        n_err++;
        $display("FAIL bp_drain_%0d: got nothing, required pc=%h", k, 32'(k * 4));
      end else if (deq_log[k] !== 32'(k * 4)) begin
        n_err++;
        $display("FAIL bp_drain_%0d: got pc=%h, required %h", k, deq_log[k], 32'(k * 4));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3;
    id_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    smp();
    step();
    redirect_valid = 1'b0;
    smp();
    n_vec++;
    if (flush_o !== 1'b1 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_flush: got flush=%b idv=%b, required 1/0", flush_o, id_valid);
    end
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redir_target: got v=%b a=%h, required v=1 a=100",
               imem_req_valid, imem_req_addr);
    end
    step();
    smp();
    n_vec++;
    if (flush_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_pulse: got flush=%b, required 0", flush_o);
    end
    wait_id("redir");
    n_vec++;
    if (id_pc !== 32'h100) begin
      n_err++;
      $display("FAIL redir_first: got pc=%h, required 100", id_pc);
    end
    step();
    smp();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h104) begin
      n_err++;
      $display("FAIL redir_second: got v=%b pc=%h, required v=1 pc=104", id_valid, id_pc);
    end
  endtask

  task automatic test_back_to_back();
    lat = 2;
    id_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h180;
    step();
    redirect_pc = 32'h200;
    smp();
    n_vec++;
    if (flush_o !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_mid: got flush=%b req=%b, required 1/0", flush_o, imem_req_valid);
    end
    step();
    redirect_valid = 1'b0;
    smp();
    n_vec++;
    if (flush_o !== 1'b1 || imem_req_addr !== 32'h200 || imem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_target: got flush=%b v=%b a=%h, required 1/1/200",
               flush_o, imem_req_valid, imem_req_addr);
    end
    wait_id("b2b");
    n_vec++;
    if (id_pc !== 32'h200) begin
      n_err++;
      $display("FAIL b2b_first: got pc=%h, required 200", id_pc);
    end
  endtask

  task automatic test_wrap();
    lat = 1;
    id_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    smp();
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_align: got v=%b a=%h, required v=1 a=fffffffc",
               imem_req_valid, imem_req_addr);
    end
    step();
    smp();
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: got v=%b a=%h, required v=1 a=0",
               imem_req_valid, imem_req_addr);
    end
    wait_id("wrap");
    n_vec++;
    if (id_pc !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_id0: got pc=%h, required fffffffc", id_pc);
    end
    step();
    smp();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_id1: got v=%b pc=%h, required v=1 pc=0", id_valid, id_pc);
    end
  endtask

  task automatic test_reset_mid();
    lat = 3;
    id_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    smp();
    n_vec++;
    if (id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup: got id_valid=%b, required 1", id_valid);
    end
    step();
    reset = 1'b1;
    smp();
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_req: got %b, required 0", imem_req_valid);
    end
    step();
    reset = 1'b0;
    smp();
    n_vec++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL midrst_state: got idv=%b v=%b a=%h, required 0/1/%h",
               id_valid, imem_req_valid, imem_req_addr, RESET_PC);
    end
    id_ready = 1'b1;
    wait_id("midrst");
    n_vec++;
    if (id_pc !== RESET_PC) begin
      n_err++;
      $display("FAIL midrst_first: got pc=%h, required %h", id_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    lat = 2;
    id_ready = 1'b1;
    rnd_ready = 1;
    apply_reset();
    deq_log.delete();
    for (int i = 0; i < 300; i++) begin
      step();
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
    end
    step();
    redirect_valid = 1'b0;
    rnd_ready = 0;
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_vec++;
    if (deq_log.size() < 50) begin
      n_err++;
      $display("FAIL rand_progress: got %0d dequeues, required >= 50", deq_log.size());
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
